// File: rtl/ahb_to_apb_bridge_if.sv
// Bus bundle for the AHB-Lite to APB3 bridge: AHB slave side, APB master side,
// the RCC clock-enable input and the APB_ACTIVE clock request.
interface ahb_to_apb_bridge_if #(
  parameter int ADDRWIDTH = 16
);
  logic                 PCLKEN;
  logic                 HSEL;
  logic [ADDRWIDTH-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic                 HWRITE;
  logic                 HREADY;
  logic [31:0]          HWDATA;
  logic                 HREADYOUT;
  logic                 HRESP;
  logic [31:0]          HRDATA;
  logic [ADDRWIDTH-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [3:0]           PSTRB;
  logic [31:0]          PWDATA;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;
  logic                 APB_ACTIVE;

  modport slave (
    input  PCLKEN, HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    input  PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA, APB_ACTIVE
  );

  modport master (
    output PCLKEN, HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    output PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA, APB_ACTIVE
  );
endinterface

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge, one transfer at a time, APB paced by PCLKEN.
// Optional macro APB_ERR_RESP_EN: PSLVERR produces a two-cycle AHB ERROR response.
module ahb_to_apb_bridge #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_to_apb_bridge_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_psel, w_psel_nxt;
  logic                 r_penable, w_penable_nxt;
  logic                 r_hreadyout, w_hreadyout_nxt;
  logic                 r_hresp, w_hresp_nxt;
  logic                 r_dphase;
  logic [ADDRWIDTH-1:0] r_paddr;
  logic                 r_pwrite;
  logic [3:0]           r_pstrb;
  logic [31:0]          r_pwdata;
  logic [31:0]          r_hrdata;
  logic                 w_req;
  logic                 w_accept;
  logic                 w_complete;
  logic [3:0]           w_strb;

  assign w_req      = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign w_accept   = (r_state == S_IDLE) & w_req;
  assign w_complete = (r_state == S_ACCESS) & bus.PCLKEN & bus.PREADY;

  always_comb begin
    w_strb = 4'h0;
    if (bus.HWRITE) begin
      case (bus.HSIZE)
        3'd0:    w_strb = 4'b0001 << bus.HADDR[1:0];
        3'd1:    w_strb = 4'b0011 << {bus.HADDR[1], 1'b0};
        default: w_strb = 4'hF;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_dphase    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_hresp     <= w_hresp_nxt;
      r_dphase    <= w_accept;
    end
  end

  // APB phases only advance on PCLKEN edges; error states run at HCLK rate
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_hreadyout_nxt = r_hreadyout;
    w_hresp_nxt     = r_hresp;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt     = S_WAIT;
          w_hreadyout_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.PCLKEN) begin
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (bus.PCLKEN) begin
          w_penable_nxt = 1'b1;
          w_state_nxt   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_complete) begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
`ifdef APB_ERR_RESP_EN
          if (bus.PSLVERR) begin
            w_hresp_nxt = 1'b1;
            w_state_nxt = S_ERR1;
          end else begin
            w_hreadyout_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end
`else
          w_hreadyout_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
`endif
        end
      end
      S_ERR1: begin
        w_hreadyout_nxt = 1'b1;
        w_state_nxt     = S_ERR2;
      end
      S_ERR2: begin
        w_hresp_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // PWDATA follows the AHB data phase, one edge after the address was accepted
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pstrb  <= 4'h0;
      r_pwdata <= 32'h0;
      r_hrdata <= 32'h0;
    end else begin
      if (w_accept) begin
        r_paddr  <= {bus.HADDR[ADDRWIDTH-1:2], 2'b00};
        r_pwrite <= bus.HWRITE;
        r_pstrb  <= w_strb;
      end
      if (r_dphase) begin
        r_pwdata <= bus.HWDATA;
      end
      if (w_complete && !r_pwrite) begin
        r_hrdata <= bus.PRDATA;
      end
    end
  end

  assign bus.HREADYOUT  = r_hreadyout;
  assign bus.HRDATA     = r_hrdata;
  assign bus.PADDR      = r_paddr;
  assign bus.PSEL       = r_psel;
  assign bus.PENABLE    = r_penable;
  assign bus.PWRITE     = r_pwrite;
  assign bus.PSTRB      = r_pstrb;
  assign bus.PWDATA     = r_pwdata;
  assign bus.APB_ACTIVE = (r_state != S_IDLE) | w_req;

  logic w_unused;
`ifdef APB_ERR_RESP_EN
  assign bus.HRESP = r_hresp;
  assign w_unused  = bus.HTRANS[0];
`else
  assign bus.HRESP = 1'b0;
  assign w_unused  = bus.HTRANS[0] | bus.PSLVERR | r_hresp;
`endif

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed bench for ahb_to_apb_bridge; expectations follow APB_ERR_RESP_EN when defined.
module tb_ahb_to_apb_bridge;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ahb_to_apb_bridge_if #(.ADDRWIDTH(16)) bus ();

  ahb_to_apb_bridge #(.ADDRWIDTH(16)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  assign bus.HREADY = bus.HREADYOUT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic w, input logic [2:0] sz);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HSIZE  = sz;
  endtask

  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.PCLKEN  = 1'b1;
    bus.HSEL    = 1'b0;
    bus.HADDR   = 16'h0;
    bus.HTRANS  = 2'b00;
    bus.HSIZE   = 3'd0;
    bus.HWRITE  = 1'b0;
    bus.HWDATA  = 32'h0;
    bus.PRDATA  = 32'h0;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;

    // reset values
    tick();
    tick();
    check("rst_hreadyout", bus.HREADYOUT, 1);
    check("rst_hresp", bus.HRESP, 0);
    check("rst_hrdata", bus.HRDATA, 0);
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_pstrb", bus.PSTRB, 0);
    check("rst_apb_active", bus.APB_ACTIVE, 0);
    rst_n = 1'b1;
    tick();

    // word write 0x0010
    addr_phase(16'h0010, 1'b1, 3'd2);
    #1;
    check("ww_active_accept", bus.APB_ACTIVE, 1);
    check("ww_hready_accept", bus.HREADYOUT, 1);
    tick();
    idle_bus();
    bus.HWDATA = 32'hDEADBEEF;
    #1;
    check("ww_e0_hreadyout", bus.HREADYOUT, 0);
    check("ww_e0_psel", bus.PSEL, 0);
    check("ww_e0_paddr", bus.PADDR, 16'h0010);
    check("ww_e0_pstrb", bus.PSTRB, 4'hF);
    check("ww_e0_pwrite", bus.PWRITE, 1);
    check("ww_e0_active", bus.APB_ACTIVE, 1);
    tick();
    check("ww_e1_psel", bus.PSEL, 1);
    check("ww_e1_penable", bus.PENABLE, 0);
    check("ww_e1_pwdata", bus.PWDATA, 32'hDEADBEEF);
    check("ww_e1_hreadyout", bus.HREADYOUT, 0);
    tick();
    check("ww_e2_penable", bus.PENABLE, 1);
    check("ww_e2_hreadyout", bus.HREADYOUT, 0);
    check("ww_e2_active", bus.APB_ACTIVE, 1);
    tick();
    check("ww_e3_psel", bus.PSEL, 0);
    check("ww_e3_penable", bus.PENABLE, 0);
    check("ww_e3_hreadyout", bus.HREADYOUT, 1);
    check("ww_e3_active", bus.APB_ACTIVE, 0);

    // byte write 0x0013
    addr_phase(16'h0013, 1'b1, 3'd0);
    tick();
    idle_bus();
    bus.HWDATA = 32'h00AB0000;
    #1;
    check("bw_paddr", bus.PADDR, 16'h0010);
    check("bw_pstrb", bus.PSTRB, 4'b1000);
    tick();
    check("bw_pwdata", bus.PWDATA, 32'h00AB0000);
    tick();
    tick();
    check("bw_done", bus.HREADYOUT, 1);

    // halfword write 0x0012 presented on the completion cycle
    addr_phase(16'h0012, 1'b1, 3'd1);
    tick();
    idle_bus();
    bus.HWDATA = 32'h1234_0000;
    #1;
    check("hw_accept_hreadyout", bus.HREADYOUT, 0);
    check("hw_pstrb", bus.PSTRB, 4'b1100);
    check("hw_paddr", bus.PADDR, 16'h0010);
    tick();
    tick();
    tick();
    check("hw_done", bus.HREADYOUT, 1);

    // word read 0x0020, PCLKEN 1-in-2, PREADY low for two PCLKEN edges
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h12345678;
    addr_phase(16'h0020, 1'b0, 3'd2);
    tick();
    idle_bus();
    #1;
    check("rd_pstrb", bus.PSTRB, 0);
    check("rd_pwrite", bus.PWRITE, 0);
    check("rd_paddr", bus.PADDR, 16'h0020);
    bus.PCLKEN = 1'b0;
    tick();
    check("rd_wait_hold_psel", bus.PSEL, 0);
    bus.PCLKEN = 1'b1;
    tick();
    check("rd_setup_psel", bus.PSEL, 1);
    check("rd_setup_penable", bus.PENABLE, 0);
    bus.PCLKEN = 1'b0;
    tick();
    check("rd_setup_hold_penable", bus.PENABLE, 0);
    bus.PCLKEN = 1'b1;
    tick();
    check("rd_access_penable", bus.PENABLE, 1);
    bus.PCLKEN = 1'b0;
    tick();
    bus.PCLKEN = 1'b1;
    tick();
    check("rd_notready1_psel", bus.PSEL, 1);
    check("rd_notready1_penable", bus.PENABLE, 1);
    bus.PCLKEN = 1'b0;
    tick();
    bus.PCLKEN = 1'b1;
    tick();
    check("rd_notready2_hreadyout", bus.HREADYOUT, 0);
    bus.PCLKEN = 1'b0;
    bus.PREADY = 1'b1;
    tick();
    check("rd_noen_psel", bus.PSEL, 1);
    check("rd_noen_hreadyout", bus.HREADYOUT, 0);
    check("rd_noen_hrdata", bus.HRDATA, 0);
    bus.PCLKEN = 1'b1;
    tick();
    check("rd_done_psel", bus.PSEL, 0);
    check("rd_done_penable", bus.PENABLE, 0);
    check("rd_done_hreadyout", bus.HREADYOUT, 1);
    check("rd_done_hrdata", bus.HRDATA, 32'h12345678);

    // PSLVERR on write 0x0004
    bus.PSLVERR = 1'b1;
    addr_phase(16'h0004, 1'b1, 3'd2);
    tick();
    idle_bus();
    bus.HWDATA = 32'h0000_5555;
    tick();
    tick();
    check("err_e2_hreadyout", bus.HREADYOUT, 0);
    tick();
    check("err_e3_psel", bus.PSEL, 0);
    check("err_hrdata_kept", bus.HRDATA, 32'h12345678);
`ifdef APB_ERR_RESP_EN
    check("err1_hresp", bus.HRESP, 1);
    check("err1_hreadyout", bus.HREADYOUT, 0);
    tick();
    check("err2_hresp", bus.HRESP, 1);
    check("err2_hreadyout", bus.HREADYOUT, 1);
    tick();
    check("err_end_hresp", bus.HRESP, 0);
    check("err_end_hreadyout", bus.HREADYOUT, 1);
`else
    check("okay_hresp", bus.HRESP, 0);
    check("okay_hreadyout", bus.HREADYOUT, 1);
    tick();
    check("okay_hresp_after", bus.HRESP, 0);
`endif
    bus.PSLVERR = 1'b0;

    // ignored transfers: HSEL=0, then HTRANS=IDLE
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = 3'd2;
    bus.HADDR  = 16'h0030;
    bus.HWDATA = 32'hDEADBEEF;
    #1;
    check("nosel_active_comb", bus.APB_ACTIVE, 0);
    tick();
    check("nosel_hreadyout", bus.HREADYOUT, 1);
    check("nosel_psel", bus.PSEL, 0);
    check("nosel_paddr", bus.PADDR, 16'h0004);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b00;
    #1;
    check("idle_active_comb", bus.APB_ACTIVE, 0);
    tick();
    check("idle_hreadyout", bus.HREADYOUT, 1);
    check("idle_psel", bus.PSEL, 0);
    check("idle_active", bus.APB_ACTIVE, 0);
    idle_bus();

    // reset while in ACCESS with PREADY low
    bus.PREADY = 1'b0;
    addr_phase(16'h0040, 1'b1, 3'd2);
    tick();
    idle_bus();
    bus.HWDATA = 32'h7777_7777;
    tick();
    tick();
    tick();
    check("rstmid_penable", bus.PENABLE, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_psel", bus.PSEL, 0);
    check("rstmid_penable_drop", bus.PENABLE, 0);
    check("rstmid_hreadyout", bus.HREADYOUT, 1);
    check("rstmid_pwdata", bus.PWDATA, 0);
    check("rstmid_active", bus.APB_ACTIVE, 0);
    #1;
    rst_n = 1'b1;
    bus.PREADY = 1'b1;
    tick();

    // word write 0x0008 after reset
    addr_phase(16'h0008, 1'b1, 3'd2);
    tick();
    idle_bus();
    bus.HWDATA = 32'hCAFEF00D;
    #1;
    check("post_paddr", bus.PADDR, 16'h0008);
    check("post_e0_hreadyout", bus.HREADYOUT, 0);
    tick();
    check("post_e1_psel", bus.PSEL, 1);
    check("post_e1_pwdata", bus.PWDATA, 32'hCAFEF00D);
    tick();
    check("post_e2_penable", bus.PENABLE, 1);
    tick();
    check("post_e3_psel", bus.PSEL, 0);
    check("post_e3_hreadyout", bus.HREADYOUT, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
